path_player: RTL and testbench

PATH_PLAYER -- requirements
Module: path_player

---
 rtl/maze_pkg.sv | 31 +++
 rtl/path_player_if.sv | 23 ++
 rtl/path_player_dir_decode.sv | 44 ++++
 rtl/path_player.sv | 168 ++++++++++++++++
 tb/tb_path_player.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: coordinate width default, direction codes, player FSM
// states, the {X,Y} location word and a saturating step-counter helper.
package maze_pkg;

  localparam int COORD_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
  } loc_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

endpackage

// File: rtl/path_player_if.sv
// Handshake bundle between the path player, the path buffer (pop/run/locIn/empStck)
// and the downstream mover (dirOut/dirValid/moveReady).
interface path_player_if #(parameter int COORD_W = maze_pkg::COORD_W_DEFAULT);

  logic                   pop;
  logic                   run;
  logic [2*COORD_W-1:0]   locIn;
  logic                   empStck;
  logic [1:0]             dirOut;
  logic                   dirValid;
  logic                   moveReady;

  modport master (
    output pop, run, dirOut, dirValid,
    input  locIn, empStck, moveReady
  );

  modport slave (
    input  pop, run, dirOut, dirValid,
    output locIn, empStck, moveReady
  );

endinterface

// File: rtl/path_player_dir_decode.sv
// Combinational step classifier: direction from prev to cur and whether the two
// cells are orthogonal neighbours (unsigned coordinates, no wrap-around).
module dir_decode
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic [2*COORD_W-1:0] prev,
  input  logic [2*COORD_W-1:0] cur,
  output logic [1:0]           dir,
  output logic                 adj
);

  localparam logic [COORD_W:0] ONE = {{COORD_W{1'b0}}, 1'b1};

  logic [COORD_W:0] px_s, py_s, cx_s, cy_s;
  logic             x_eq_s, y_eq_s;

  // One extra bit keeps max+1 from aliasing back onto 0.
  assign px_s   = {1'b0, prev[2*COORD_W-1:COORD_W]};
  assign py_s   = {1'b0, prev[COORD_W-1:0]};
  assign cx_s   = {1'b0, cur[2*COORD_W-1:COORD_W]};
  assign cy_s   = {1'b0, cur[COORD_W-1:0]};
  assign x_eq_s = (cx_s == px_s);
  assign y_eq_s = (cy_s == py_s);

  // Classify the step; anything that is not a single orthogonal move is illegal.
  always_comb begin
    dir = DIR_UP;
    adj = 1'b1;
    if (x_eq_s && (cy_s + ONE == py_s)) begin
      dir = DIR_UP;
    end else if (y_eq_s && (cx_s == px_s + ONE)) begin
      dir = DIR_RIGHT;
    end else if (x_eq_s && (cy_s == py_s + ONE)) begin
      dir = DIR_DOWN;
    end else if (y_eq_s && (cx_s + ONE == px_s)) begin
      dir = DIR_LEFT;
    end else begin
      adj = 1'b0;
    end
  end

endmodule

// File: rtl/path_player.sv
// Replays a stored path as a stream of direction steps to a downstream mover.
// Optional step counter enabled by macro PATH_STEP_COUNT_EN (tied to 0 otherwise).
module path_player
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  path_player_if.master      bus,
  output logic [7:0]         stepCount,
  output logic               busy,
  output logic               finished,
  output logic               err
);

  state_e               state_q, state_d;
  logic [2*COORD_W-1:0] cur_q, cur_d;
  logic [2*COORD_W-1:0] prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic [1:0]           dir_q, dir_d;
  logic                 dir_valid_q, dir_valid_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic                 err_q, err_d;

  logic [1:0]           dec_dir_s;
  logic                 dec_adj_s;
  logic                 start_go_s;
  logic                 accept_s;

  dir_decode #(.COORD_W(COORD_W)) u_dir_decode (
    .prev (prev_q),
    .cur  (bus.locIn),
    .dir  (dec_dir_s),
    .adj  (dec_adj_s)
  );

  assign start_go_s = (state_q == IDLE) && start;
  assign accept_s   = (state_q == EMIT) && bus.moveReady;

  // The pop decision must see this cycle's empStck, so pop/run decode the state.
  assign bus.pop      = (state_q == REQ) && !bus.empStck;
  assign bus.run      = (state_q == REQ) && !bus.empStck;
  assign bus.dirOut   = dir_q;
  assign bus.dirValid = dir_valid_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign err          = err_q;

  // Playback sequencing: next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    dir_d       = dir_q;
    dir_valid_d = dir_valid_q;
    finished_d  = finished_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start_go_s) begin
          state_d     = REQ;
          finished_d  = 1'b0;
          err_d       = 1'b0;
          have_prev_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.empStck) begin
          state_d = DONE;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        cur_d = bus.locIn;
        if (!have_prev_q) begin
          prev_d      = bus.locIn;
          have_prev_d = 1'b1;
          state_d     = REQ;
        end else if (dec_adj_s) begin
          dir_d       = dec_dir_s;
          dir_valid_d = 1'b1;
          state_d     = EMIT;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      EMIT: begin
        if (accept_s) begin
          dir_valid_d = 1'b0;
          prev_d      = cur_q;
          state_d     = REQ;
        end else begin
          dir_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d == REQ) || (state_d == CAPT) || (state_d == EMIT);
    finished_d = finished_d | (state_d == DONE);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      dir_q       <= 2'b00;
      dir_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      err_q       <= err_d;
    end
  end

`ifdef PATH_STEP_COUNT_EN
  logic [7:0] step_cnt_q, step_cnt_d;

  // Accepted-step counter, cleared by a fresh start, saturating at 8'hFF.
  always_comb begin
    if (start_go_s) begin
      step_cnt_d = 8'h00;
    end else if (accept_s) begin
      step_cnt_d = sat_inc8(step_cnt_q);
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // Step counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt_q <= 8'h00;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign stepCount = step_cnt_q;
`else
  assign stepCount = 8'h00;
`endif

endmodule

// File: tb/tb_path_player.sv
// Self-checking bench for path_player: directed vector table, reset-in-EMIT and
// saturation sequences, and random paths checked against a path-walking model.
module tb_path_player;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] stepCount;
  logic       busy, finished, err;

  path_player_if #(.COORD_W(4)) bus();

  path_player #(.COORD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .stepCount (stepCount),
    .busy      (busy),
    .finished  (finished),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          stall;
    logic [63:0] locs;
    logic [15:0] dirs;
    int          steps;
    bit          err;
    int          pops;
  } vec_t;

  vec_t       tbl[10];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] mem[0:299];
  int         got_q[$];
  int         exp_q[$];
  int         m_steps, m_pops;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_count(input int n);
`ifdef PATH_STEP_COUNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  // Reference: walk the path with signed integer deltas.
  task automatic model(input int len);
    int dx, dy, d;
    m_steps = 0; m_pops = 0; m_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      m_pops++;
      if (i > 0) begin
        dx = int'(mem[i][7:4]) - int'(mem[i-1][7:4]);
        dy = int'(mem[i][3:0]) - int'(mem[i-1][3:0]);
        if (dx == 0 && dy == -1)      d = 0;
        else if (dx == 1 && dy == 0)  d = 1;
        else if (dx == 0 && dy == 1)  d = 2;
        else if (dx == -1 && dy == 0) d = 3;
        else d = -1;
        if (d < 0) begin
          m_err = 1'b1;
          break;
        end
        exp_q.push_back(d);
        m_steps++;
      end
    end
  endtask

  // Drives one playback; plays path buffer and mover. abort_steps>=0 returns in EMIT.
  task automatic run_path(input int len, input int stall, input int abort_steps,
                          output int cyc_done, output int pops, output int acc,
                          output bit stable_ok, output bit cnt_ok, output bit drop_ok);
    int rd = 0; int wait_cnt = 0; bit pend = 1'b0; bit acc_last = 1'b0;
    logic [1:0] hold_dir = 2'b00;
    cyc_done = -1; pops = 0; acc = 0; stable_ok = 1'b1; cnt_ok = 1'b1; drop_ok = 1'b1;
    got_q.delete();
    bus.empStck   = (len == 0);
    bus.moveReady = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 5000; c++) begin
      if (pend) begin
        bus.locIn   = mem[rd];
        rd++;
        pend        = 1'b0;
        bus.empStck = (rd >= len);
      end
      #1;
      if (finished) begin
        cyc_done = c;
        break;
      end
      if (stepCount !== exp_count(acc)) cnt_ok = 1'b0;
      if (acc_last && bus.dirValid) drop_ok = 1'b0;
      acc_last = 1'b0;
      if (abort_steps >= 0 && acc == abort_steps && bus.dirValid) return;
      if (bus.pop) begin
        pops++;
        pend = 1'b1;
      end
      if (bus.dirValid) begin
        if (wait_cnt == 0) hold_dir = bus.dirOut;
        else if (bus.dirOut !== hold_dir) stable_ok = 1'b0;
        if (wait_cnt >= stall) begin
          bus.moveReady = 1'b1;
          got_q.push_back(int'(bus.dirOut));
          acc++;
          wait_cnt = 0;
          acc_last = 1'b1;
        end else begin
          bus.moveReady = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.moveReady = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_run(input string tag, input int len, input int stall);
    int cyc, pops, acc, exp_cyc;
    bit st_ok, c_ok, d_ok;
    run_path(len, stall, -1, cyc, pops, acc, st_ok, c_ok, d_ok);
    exp_cyc = 2 * m_pops + m_steps * (1 + stall) + (m_err ? 0 : 1) + 1;
    chk({tag, " done_cycle"}, cyc, exp_cyc);
    chk({tag, " pops"}, pops, m_pops);
    chk({tag, " accepted"}, acc, m_steps);
    chk({tag, " err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, " stepCount"}, {24'd0, stepCount}, {24'd0, exp_count(m_steps)});
    chk({tag, " dir_stable"}, {31'd0, st_ok}, 32'd1);
    chk({tag, " count_track"}, {31'd0, c_ok}, 32'd1);
    chk({tag, " valid_drop"}, {31'd0, d_ok}, 32'd1);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, " dir"}, got_q[i], exp_q[i]);
    bus.moveReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " sticky"}, {29'd0, finished, err, busy}, {29'd0, 1'b1, m_err, 1'b0});
  endtask

  initial begin
    int cyc, pops, acc, len, stall, r, cnt;
    bit st_ok, c_ok, d_ok;
    logic [3:0] x, y;
    logic [7:0] sq[4];

    tbl[0] = '{4, 0, 64'h01_11_10_00, 16'b11_10_01, 3, 1'b0, 4};
    tbl[1] = '{4, 5, 64'h01_11_10_00, 16'b11_10_01, 3, 1'b0, 4};
    tbl[2] = '{0, 0, 64'h0,           16'h0,        0, 1'b0, 0};
    tbl[3] = '{2, 0, 64'h11_00,       16'h0,        0, 1'b1, 2};
    tbl[4] = '{2, 0, 64'h00_0F,       16'h0,        0, 1'b1, 2};
    tbl[5] = '{2, 1, 64'h00_F0,       16'h0,        0, 1'b1, 2};
    tbl[6] = '{3, 0, 64'h34_34_33,    16'b10,       1, 1'b1, 3};
    tbl[7] = '{1, 0, 64'h77,          16'h0,        0, 1'b0, 1};
    tbl[8] = '{4, 2, 64'h30_20_21_22, 16'b01_00_00, 3, 1'b0, 4};
    tbl[9] = '{3, 1, 64'h41_40_50,    16'b10_11,    2, 1'b0, 3};

    rst = 1'b0; start = 1'b0;
    bus.locIn = 8'h00; bus.empStck = 1'b0; bus.moveReady = 1'b0;
    #12;
    chk("reset_state", {16'd0, bus.pop, bus.run, bus.dirValid, bus.dirOut, stepCount, busy, finished, err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_pop", {30'd0, bus.pop, busy}, 32'd0);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 8; i++) mem[i] = tbl[t].locs[8*i +: 8];
      m_steps = tbl[t].steps; m_pops = tbl[t].pops; m_err = tbl[t].err;
      exp_q.delete();
      for (int i = 0; i < tbl[t].steps; i++) exp_q.push_back(int'(tbl[t].dirs[2*i +: 2]));
      check_run($sformatf("vec%0d", t), tbl[t].len, tbl[t].stall);
    end

    // Reset asserted while the third step is waiting in EMIT.
    for (int i = 0; i < 4; i++) mem[i] = tbl[0].locs[8*i +: 8];
    run_path(4, 0, 2, cyc, pops, acc, st_ok, c_ok, d_ok);
    chk("pre_rst_emit", {31'd0, bus.dirValid}, 32'd1);
    chk("pre_rst_count", {24'd0, stepCount}, {24'd0, exp_count(2)});
    rst = 1'b0;
    #1;
    chk("rst_outputs", {16'd0, bus.pop, bus.run, bus.dirValid, bus.dirOut, stepCount, busy, finished, err}, 32'd0);
    bus.empStck = 1'b0; bus.moveReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (bus.pop) cnt++;
    end
    chk("no_pop_after_rst", cnt, 0);
    model(4);
    check_run("after_rst", 4, 0);

    // Long square loop drives the counter past its ceiling.
    sq[0] = 8'h00; sq[1] = 8'h10; sq[2] = 8'h11; sq[3] = 8'h01;
    for (int i = 0; i < 300; i++) mem[i] = sq[i % 4];
    model(300);
    check_run("saturate", 300, 0);

    for (int t = 0; t < 40; t++) begin
      len   = $urandom_range(0, 12);
      stall = $urandom_range(0, 3);
      mem[0] = 8'($urandom);
      for (int i = 1; i < len; i++) begin
        r = $urandom_range(0, 11);
        x = mem[i-1][7:4];
        y = mem[i-1][3:0];
        if (r == 0) mem[i] = 8'($urandom);
        else if (r == 1) mem[i] = mem[i-1];
        else begin
          case (r % 4)
            0: y = y - 4'd1;
            1: x = x + 4'd1;
            2: y = y + 4'd1;
            default: x = x - 4'd1;
          endcase
          mem[i] = {x, y};
        end
      end
      model(len);
      check_run($sformatf("rand%0d", t), len, stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
